// File: rtl/push_button_led_ctrl.sv
// Purpose : debounced active-low push buttons select a one-hot LED that then steps on a divided tick.
// Latency : a clean press held from edge k gives Press_valid/Press_idx/LED update at edge k+DEBOUNCE_CYCLES+2.
// Backpressure: none; press events are single-cycle pulses and simultaneous presses keep only the lowest index.
//
// Ports:
//   Clk          system clock
//   Rst_n        asynchronous active-low reset
//   Switch       raw buttons, 0 = pressed, asynchronous to Clk
//   Mode         00 rotate right, 01 rotate left, 10 hold, 11 ping-pong
//   LED          one-hot LED pattern
//   Press_valid  one-cycle pulse for an accepted press
//   Press_idx    index of the accepted press (holds its last value between pulses)
//   Btn_state    debounced button state, 1 = pressed
//
// Build option: define PB_HOLD_PAUSE_EN to freeze stepping while any button is held down.

module push_button_led_ctrl #(
  parameter int N_BTN           = 8,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int TICK_DIV        = 25000000,
  localparam int IDXW           = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [N_BTN-1:0] Switch,
  input  logic [1:0]       Mode,
  output logic [N_BTN-1:0] LED,
  output logic             Press_valid,
  output logic [IDXW-1:0]  Press_idx,
  output logic [N_BTN-1:0] Btn_state
);

  // Debounce counter is sized to hold DEBOUNCE_CYCLES so it can never wrap.
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  logic [N_BTN-1:0] sync1, sync2;
  logic [CW-1:0]    db_cnt_q [N_BTN];
  logic [CW-1:0]    db_cnt_d [N_BTN];
  logic [N_BTN-1:0] stable_q, stable_d, stable_dly_q;
  logic [N_BTN-1:0] press_vec;
  logic             press_any;
  logic [IDXW-1:0]  press_sel;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic             tick;
  logic             pause;
  logic [N_BTN-1:0] led_q, led_d;
  dir_e             dir_q, dir_d;
  logic             pv_q;
  logic [IDXW-1:0]  pidx_q, pidx_d;

  // Synchronisers idle at all-ones (buttons released).
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= Switch;
      sync2 <= sync1;
    end
  end

  // Per-bit debounce: count consecutive samples that disagree with the
  // accepted state; flip once DEBOUNCE_CYCLES of them have been seen.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < N_BTN; i++) begin
      db_cnt_d[i] = db_cnt_q[i];
      if (~sync2[i] == stable_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        stable_d[i] = ~stable_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + CW'(1);
      end
    end
  end

  // Press edge is taken from the registered debounced state so the event
  // lands one cycle after Btn_state rises.
  assign press_vec = stable_q & ~stable_dly_q;

  // Scan downward so the lowest set index is the one that sticks.
  always_comb begin
    press_any = 1'b0;
    press_sel = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (press_vec[i]) begin
        press_any = 1'b1;
        press_sel = IDXW'(i);
      end
    end
  end

  assign tick = (tcnt_q == TICK_LAST);

`ifdef PB_HOLD_PAUSE_EN
  assign pause = |stable_q;
`else
  assign pause = 1'b0;
`endif

  // LED / tick / direction next-state. A press always wins over a tick and
  // restarts the tick period; pause keeps the counter pinned at zero.
  always_comb begin
    tcnt_d = tick ? '0 : tcnt_q + TW'(1);
    led_d  = led_q;
    dir_d  = dir_q;
    pidx_d = pidx_q;
    if (press_any) begin
      led_d  = N_BTN'(1) << press_sel;
      tcnt_d = '0;
      pidx_d = press_sel;
    end else if (pause) begin
      tcnt_d = '0;
    end else if (tick && (N_BTN > 1)) begin
      case (Mode)
        2'b00: led_d = (led_q >> 1) | (led_q << (N_BTN - 1));
        2'b01: led_d = (led_q << 1) | (led_q >> (N_BTN - 1));
        2'b10: led_d = led_q;
        2'b11: begin
          // Bounce off an end: reverse and move away in the same tick.
          if (dir_q == DIR_LEFT) begin
            if (led_q[N_BTN-1]) begin
              dir_d = DIR_RIGHT;
              led_d = led_q >> 1;
            end else begin
              led_d = led_q << 1;
            end
          end else begin
            if (led_q[0]) begin
              dir_d = DIR_LEFT;
              led_d = led_q << 1;
            end else begin
              led_d = led_q >> 1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < N_BTN; i++) db_cnt_q[i] <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      tcnt_q       <= '0;
      led_q        <= N_BTN'(1);
      dir_q        <= DIR_LEFT;
      pv_q         <= 1'b0;
      pidx_q       <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) db_cnt_q[i] <= db_cnt_d[i];
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      tcnt_q       <= tcnt_d;
      led_q        <= led_d;
      dir_q        <= dir_d;
      pv_q         <= press_any;
      pidx_q       <= pidx_d;
    end
  end

  assign LED         = led_q;
  assign Press_valid = pv_q;
  assign Press_idx   = pidx_q;
  assign Btn_state   = stable_q;

endmodule

// File: tb/tb_push_button_led_ctrl.sv
// Purpose : self-checking bench for push_button_led_ctrl (N_BTN=8, DEBOUNCE_CYCLES=4, TICK_DIV=10).
// Latency : reference model predicts outputs edge by edge from input history.
// Backpressure: n/a.

module tb_push_button_led_ctrl;

  localparam int N = 8;
  localparam int D = 4;
  localparam int T = 10;
  localparam int HMAX = 8191;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b1;
  logic [7:0] Switch = 8'hff;
  logic [1:0] Mode = 2'b00;
  logic [7:0] LED;
  logic       Press_valid;
  logic [2:0] Press_idx;
  logic [7:0] Btn_state;

  push_button_led_ctrl #(
    .N_BTN(N),
    .DEBOUNCE_CYCLES(D),
    .TICK_DIV(T)
  ) dut (
    .Clk(Clk),
    .Rst_n(Rst_n),
    .Switch(Switch),
    .Mode(Mode),
    .LED(LED),
    .Press_valid(Press_valid),
    .Press_idx(Press_idx),
    .Btn_state(Btn_state)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad = 0;
  int pv_cnt = 0;

  // Reference model: history of raw switch values and debounced states per
  // edge since reset release, LED as an integer position.
  int         e;
  logic [7:0] sw_hist   [0:HMAX];
  logic [7:0] stab_hist [0:HMAX];
  int         m_pos;
  int         m_dir;   // 0 = toward bit N-1, 1 = toward bit 0
  int         m_next;  // edge number of next scheduled step
  logic       m_pv;
  int         m_idx;
  logic [7:0] m_btn;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] swat(input int k);
    if (k < 1 || k > HMAX) return 8'hff;
    return sw_hist[k];
  endfunction

  function automatic logic [7:0] stat(input int k);
    if (k < 1 || k > HMAX) return 8'h00;
    return stab_hist[k];
  endfunction

  task automatic model_reset();
    e      = 0;
    m_pos  = 0;
    m_dir  = 0;
    m_next = T;
    m_pv   = 1'b0;
    m_idx  = 0;
    m_btn  = 8'h00;
  endtask

  task automatic model_edge();
    logic [7:0] prev, nst, pvec, smp;
    bit alld, paused;
    e++;
    if (e <= HMAX) sw_hist[e] = Switch;
    // A bit flips when the last D synchronised samples (raw delayed by two
    // edges, inverted) all disagree with the previously accepted state.
    prev = stat(e - 1);
    nst  = prev;
    for (int b = 0; b < N; b++) begin
      alld = 1'b1;
      for (int j = e - D + 1; j <= e; j++) begin
        smp = ~swat(j - 2);
        if (smp[b] == prev[b]) alld = 1'b0;
      end
      if (alld) nst[b] = ~prev[b];
    end
    if (e <= HMAX) stab_hist[e] = nst;
    m_btn = nst;
    pvec  = stat(e - 1) & ~stat(e - 2);
    m_pv  = (pvec != 8'h00);
`ifdef PB_HOLD_PAUSE_EN
    paused = (stat(e - 1) != 8'h00);
`else
    paused = 1'b0;
`endif
    if (m_pv) begin
      m_idx = 0;
      while (!pvec[m_idx]) m_idx++;
      m_pos  = m_idx;
      m_next = e + T;
    end else if (paused) begin
      m_next = e + T;
    end else if (e == m_next) begin
      m_next = e + T;
      case (Mode)
        2'b00: m_pos = (m_pos + N - 1) % N;
        2'b01: m_pos = (m_pos + 1) % N;
        2'b10: ;
        2'b11: begin
          if (m_dir == 0) begin
            if (m_pos == N - 1) begin m_dir = 1; m_pos--; end
            else m_pos++;
          end else begin
            if (m_pos == 0) begin m_dir = 0; m_pos++; end
            else m_pos--;
          end
        end
      endcase
    end
  endtask

  task automatic tick1();
    logic [7:0] exp_led;
    @(posedge Clk);
    model_edge();
    #1;
    if (Press_valid) pv_cnt++;
    exp_led = 8'(1 << m_pos);
    chk("led", LED, exp_led);
    chk("press_valid", Press_valid, m_pv);
    chk("btn_state", Btn_state, m_btn);
    if (m_pv) chk("press_idx", Press_idx, m_idx);
    @(negedge Clk);
  endtask

  initial begin
    int k, p, n;
    logic [7:0] last;
    logic [7:0] seq [9];
    seq = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    model_reset();

    // 1: reset values, then free rotation right
    #2 Rst_n = 1'b0;
    #12;
    chk("rst_led", LED, 8'h01);
    chk("rst_pv", Press_valid, 1'b0);
    chk("rst_idx", Press_idx, 3'd0);
    chk("rst_btn", Btn_state, 8'h00);
    @(negedge Clk);
    Rst_n = 1'b1;
    model_reset();
    repeat (10) tick1();
    chk("t1_led_at10", LED, 8'h80);
    repeat (10) tick1();
    chk("t1_led_at20", LED, 8'h40);
    chk("t1_no_press", pv_cnt, 0);

    // 2: short glitch ignored, then a real press with exact latency
    Switch[3] = 1'b0;
    repeat (3) tick1();
    Switch = 8'hff;
    repeat (10) tick1();
    chk("t2_glitch_btn", Btn_state, 8'h00);
    chk("t2_glitch_pv", pv_cnt, 0);
    Switch[3] = 1'b0;
    k = e + 1;
    while (e < k + D) tick1();
    tick1();
    chk("t2_pv_early", Press_valid, 1'b0);
    tick1();
    chk("t2_pv", Press_valid, 1'b1);
    chk("t2_idx", Press_idx, 3'd3);
    chk("t2_led", LED, 8'h08);
    chk("t2_one_pulse", pv_cnt, 1);
    Switch = 8'hff;
    repeat (12) tick1();

    // 3: simultaneous presses, lowest index wins
    Switch = ~8'h24;
    k = e + 1;
    while (e < k + D + 2) tick1();
    chk("t3_pv", Press_valid, 1'b1);
    chk("t3_idx", Press_idx, 3'd2);
    chk("t3_led", LED, 8'h04);
    chk("t3_btn", Btn_state, 8'h24);
    tick1();
    chk("t3_single", Press_valid, 1'b0);
    Switch = 8'hff;
    repeat (12) tick1();

    // 4: ping-pong from 40
    Mode = 2'b10;
    Switch = ~8'h40;
    k = e + 1;
    while (e < k + D + 2) tick1();
    chk("t4_start", LED, 8'h40);
    Mode = 2'b11;
    Switch = 8'hff;
    for (int s = 0; s < 9; s++) begin
      last = LED;
      n = 0;
      while (LED === last && n < 40) begin
        tick1();
        n++;
      end
      chk("t4_seq", LED, seq[s]);
    end

    // 5: press lands on the same edge as a tick
    Mode = 2'b10;
    Switch = ~8'h10;
    k = e + 1;
    while (e < k + D + 2) tick1();
    chk("t5_start", LED, 8'h10);
    Switch = 8'hff;
    repeat (12) tick1();
    p = m_next;
    while (p < e + D + 3) p += T;
    k = p - D - 2;
    while (e < k - 1) tick1();
    Mode = 2'b01;
    Switch = ~8'h01;
    while (e < p) tick1();
    chk("t5_pv", Press_valid, 1'b1);
    chk("t5_led", LED, 8'h01);
    Switch = 8'hff;
    repeat (9) tick1();
    chk("t5_hold9", LED, 8'h01);
    tick1();
`ifdef PB_HOLD_PAUSE_EN
    chk("t5_step10", LED, 8'h01);
`else
    chk("t5_step10", LED, 8'h02);
`endif

    // 6: reset mid-debounce and mid-tick, then hold a button
    Mode = 2'b00;
    Switch = ~8'h80;
    tick1();
    tick1();
    #2 Rst_n = 1'b0;
    #1;
    chk("t6_rst_led", LED, 8'h01);
    chk("t6_rst_pv", Press_valid, 1'b0);
    chk("t6_rst_idx", Press_idx, 3'd0);
    chk("t6_rst_btn", Btn_state, 8'h00);
    @(negedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    model_reset();
    repeat (40) tick1();
    Switch = 8'hff;
    repeat (30) tick1();

    // 7: random buttons and modes against the model
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 49) == 0) Mode = 2'($urandom_range(0, 3));
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 11) == 0) Switch[b] = ~Switch[b];
      end
      tick1();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
